// File: rtl/program_counter_pkg.sv
// program_counter_pkg: shared core constants for the RV32 fetch path
package program_counter_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/program_counter.sv
// program_counter: architectural PC register with sequential successor and alignment flag
module program_counter #(
  parameter int XLEN = program_counter_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = program_counter_pkg::RESET_VECTOR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_next_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_misaligned
);
  import program_counter_pkg::*;
  logic [XLEN-1:0] pc_d, pc_q;
  always_comb pc_d = i_rst ? RESET_VECTOR : i_next_pc;
  always_ff @(posedge i_clk) pc_q <= pc_d;
  assign o_pc = pc_q;
  assign o_pc_plus4 = pc_q + XLEN'(INSTR_BYTES);
  assign o_misaligned = |pc_q[1:0];
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vectors with a queue scoreboard and an edge-driven monitor
module tb_program_counter;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] p4;
    logic        mis;
  } exp_t;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_next_pc = '0;
  logic [31:0] o_pc, o_pc_plus4;
  logic        o_misaligned;
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  program_counter dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_next_pc(i_next_pc),
    .o_pc(o_pc),
    .o_pc_plus4(o_pc_plus4),
    .o_misaligned(o_misaligned)
  );
  always #5 i_clk = ~i_clk;
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic rst, input logic [31:0] nxt,
                      input logic [31:0] e_pc, input logic [31:0] e_p4, input logic e_mis);
    @(negedge i_clk);
    i_rst = rst;
    i_next_pc = nxt;
    sb.push_back('{e_pc, e_p4, e_mis});
  endtask
  always @(posedge i_clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check32("o_pc", o_pc, e.pc);
      check32("o_pc_plus4", o_pc_plus4, e.p4);
      check32("o_misaligned", {31'b0, o_misaligned}, {31'b0, e.mis});
    end
  end
  initial begin
    step(1'b1, 32'h64,        32'h0,         32'h4,        1'b0);
    step(1'b0, 32'h68,        32'h68,        32'h6C,       1'b0);
    step(1'b0, 32'h6C,        32'h6C,        32'h70,       1'b0);
    step(1'b0, 32'h70,        32'h70,        32'h74,       1'b0);
    step(1'b1, 32'h1000,      32'h0,         32'h4,        1'b0);
    step(1'b1, 32'h1000,      32'h0,         32'h4,        1'b0);
    step(1'b0, 32'h1000,      32'h1000,      32'h1004,     1'b0);
    step(1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,        1'b0);
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3,        1'b1);
    step(1'b0, 32'h66,        32'h66,        32'h6A,       1'b1);
    step(1'b0, 32'h3,         32'h3,         32'h7,        1'b1);
    step(1'b0, 32'h1,         32'h1,         32'h5,        1'b1);
    step(1'b0, 32'h68,        32'h68,        32'h6C,       1'b0);
    step(1'b0, 32'h200,       32'h200,       32'h204,      1'b0);
    #1 i_rst = 1'b1;
    #1 i_rst = 1'b0;
    #1;
    check32("mid_pulse_pc", o_pc, 32'h68);
    check32("mid_pulse_plus4", o_pc_plus4, 32'h6C);
    step(1'b0, 32'h8,         32'h8,         32'hC,        1'b0);
    repeat (3) @(posedge i_clk);
    #2;
    check32("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
